// File: rtl/vt57_pkg.sv
// vt57_pkg: shared constants, FSM state encoding and helpers for the vt57 DMA controller.
package vt57_pkg;

    localparam int unsigned NCH = 4;   // channel count
    localparam int unsigned AW  = 16;  // memory address width
    localparam int unsigned DW  = 8;   // data width
    localparam int unsigned CW  = 14;  // byte-count field width inside the count register

    // Register offsets from BASE: 2n = addr ch n, 2n+1 = count ch n
    localparam logic [3:0] OFF_MODE = 4'd8;

    // Transfer type in count[15:14]; any code other than OP_READ behaves as a verify
    localparam logic [1:0] OP_VERIFY = 2'b00;
    localparam logic [1:0] OP_READ   = 2'b10;

    // Mode register bit positions; bits [3:0] are the channel enables
    localparam int unsigned MODE_TCSTOP   = 6;
    localparam int unsigned MODE_AUTOLOAD = 7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_ADDR,
        S_READ,
        S_XFER
    } state_t;

    // Fixed priority: the lowest-numbered active request wins
    function automatic logic [1:0] prio_sel(input logic [NCH-1:0] req);
        logic [1:0] sel;
        sel = 2'd0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (req[i]) sel = 2'(i);
        end
        return sel;
    endfunction

endpackage

// File: rtl/vt57_channel.sv
// vt57_channel: one DMA channel's address/count registers.
// Ports: i_wr_addr/i_wr_cnt + i_hi/i_wdata = CPU byte write, i_step = post-transfer
// increment/decrement, i_reload/i_reload_* = autoload copy, o_addr/o_count = current values.
module vt57_channel
    import vt57_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    input  logic          i_wr_addr,
    input  logic          i_wr_cnt,
    input  logic          i_hi,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_step,
    input  logic          i_reload,
    input  logic [AW-1:0] i_reload_addr,
    input  logic [AW-1:0] i_reload_cnt,
    output logic [AW-1:0] o_addr,
    output logic [AW-1:0] o_count
);

    logic [AW-1:0] r_addr;
    logic [AW-1:0] r_count;

    // A CPU byte write suppresses any hardware update of that register in the same cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_addr  <= '0;
            r_count <= '0;
        end else begin
            if (i_wr_addr) begin
                if (i_hi) r_addr[AW-1:DW] <= i_wdata;
                else      r_addr[DW-1:0]  <= i_wdata;
            end else if (i_reload) begin
                r_addr <= i_reload_addr;
            end else if (i_step) begin
                r_addr <= r_addr + AW'(1);
            end

            // Only the byte count decrements; the op bits are preserved and the count wraps to 3FFF
            if (i_wr_cnt) begin
                if (i_hi) r_count[AW-1:DW] <= i_wdata;
                else      r_count[DW-1:0]  <= i_wdata;
            end else if (i_reload) begin
                r_count <= i_reload_cnt;
            end else if (i_step) begin
                r_count[CW-1:0] <= r_count[CW-1:0] - CW'(1);
            end
        end
    end

    assign o_addr  = r_addr;
    assign o_count = r_count;

endmodule

// File: rtl/vt57_dma.sv
// vt57_dma: KR580VT57 (i8257-style) 4-channel DMA controller.
// CPU side: cpu_address/cpu_out/cpu_we/cpu_rd -> cpu_in (registered, valid the cycle after cpu_rd).
// Bus side: hold/hlda handshake, address out, in = memory read data.
// Device side: drq level requests, dev_data/dev_we/dack/tc strobes for one cycle per byte.
module vt57_dma
    import vt57_pkg::*;
#(
    parameter logic [15:0] BASE = 16'hE000
)
(
    input  logic           clock,
    input  logic           reset,
    input  logic [AW-1:0]  cpu_address,
    input  logic [DW-1:0]  cpu_out,
    input  logic           cpu_we,
    input  logic           cpu_rd,
    output logic [DW-1:0]  cpu_in,
    input  logic [NCH-1:0] drq,
    output logic           hold,
    input  logic           hlda,
    output logic [AW-1:0]  address,
    input  logic [DW-1:0]  in,
    output logic [DW-1:0]  dev_data,
    output logic           dev_we,
    output logic [NCH-1:0] dack,
    output logic           tc
);

    state_t         r_state;
    logic [1:0]     r_ch;
    logic           r_hold;
    logic [AW-1:0]  r_address;
    logic [DW-1:0]  r_dev_data;
    logic           r_dev_we;
    logic [NCH-1:0] r_dack;
    logic           r_tc;
    logic [NCH-1:0] r_en;
    logic           r_tcstop;
    logic           r_autoload;
    logic           r_ff;
    logic [NCH-1:0] r_tc_flags;
    logic [DW-1:0]  r_cpu_in;

    logic [AW-1:0]  w_off;
    logic           w_wr;
    logic           w_rd;
    logic           w_is_mode;
    logic           w_is_cnt;
    logic [1:0]     w_reg_ch;
    logic           w_mode_wr;
    logic [NCH-1:0] w_wr_addr;
    logic [NCH-1:0] w_wr_cnt;
    logic [AW-1:0]  w_addr  [NCH];
    logic [AW-1:0]  w_count [NCH];
    logic [AW-1:0]  w_rd_reg;
    logic           w_xfer;
    logic [NCH-1:0] w_ch_oh;
    logic [NCH-1:0] w_step;
    logic [NCH-1:0] w_tc_set;
    logic           w_al_hit;
    logic [NCH-1:0] w_reload;
    logic [NCH-1:0] w_stop;
    logic [NCH-1:0] w_en_nxt;
    logic [NCH-1:0] w_req;
    logic [NCH-1:0] w_req_nxt;

    // CPU decode; a simultaneous write and read is treated as a write only
    assign w_off     = cpu_address - BASE;
    assign w_wr      = cpu_we && (w_off < 16'd9);
    assign w_rd      = cpu_rd && !cpu_we && (w_off < 16'd9);
    assign w_is_mode = (w_off[3:0] == OFF_MODE);
    assign w_is_cnt  = w_off[0];
    assign w_reg_ch  = w_off[2:1];
    assign w_mode_wr = w_wr && w_is_mode;

    // Channel write enables; with autoload, ch2 writes are mirrored into ch3
    always_comb begin
        w_wr_addr = '0;
        w_wr_cnt  = '0;
        if (w_wr && !w_is_mode) begin
            if (w_is_cnt) w_wr_cnt[w_reg_ch]  = 1'b1;
            else          w_wr_addr[w_reg_ch] = 1'b1;
            if (r_autoload && (w_reg_ch == 2'd2)) begin
                if (w_is_cnt) w_wr_cnt[3]  = 1'b1;
                else          w_wr_addr[3] = 1'b1;
            end
        end
    end

    // End-of-transfer bookkeeping, all applied on the clock that leaves XFER
    assign w_xfer    = (r_state == S_XFER);
    assign w_ch_oh   = NCH'(1) << r_ch;
    assign w_step    = w_xfer ? w_ch_oh : '0;
    assign w_tc_set  = (w_xfer && r_tc) ? w_ch_oh : '0;
    assign w_al_hit  = w_xfer && r_tc && r_autoload && (r_ch == 2'd2);
    assign w_reload  = {1'b0, w_al_hit, 2'b00};
    assign w_stop    = (r_tcstop && !w_al_hit) ? w_tc_set : '0;
    assign w_en_nxt  = w_mode_wr ? cpu_out[NCH-1:0] : (r_en & ~w_stop);
    assign w_req     = drq & r_en;
    assign w_req_nxt = drq & w_en_nxt;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        vt57_channel u_ch (
            .clock        (clock),
            .reset        (reset),
            .i_wr_addr    (w_wr_addr[g]),
            .i_wr_cnt     (w_wr_cnt[g]),
            .i_hi         (r_ff),
            .i_wdata      (cpu_out),
            .i_step       (w_step[g]),
            .i_reload     (w_reload[g]),
            .i_reload_addr(w_addr[NCH-1]),
            .i_reload_cnt (w_count[NCH-1]),
            .o_addr       (w_addr[g]),
            .o_count      (w_count[g])
        );
    end

    assign w_rd_reg = w_is_cnt ? w_count[w_reg_ch] : w_addr[w_reg_ch];

    // CPU-visible state: mode, byte flip-flop, TC flags and read-data register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_en       <= '0;
            r_tcstop   <= 1'b0;
            r_autoload <= 1'b0;
            r_ff       <= 1'b0;
            r_tc_flags <= '0;
            r_cpu_in   <= '0;
        end else begin
            r_en <= w_en_nxt;
            if (w_mode_wr) begin
                r_tcstop   <= cpu_out[MODE_TCSTOP];
                r_autoload <= cpu_out[MODE_AUTOLOAD];
                r_ff       <= 1'b0;
            end else if ((w_wr || w_rd) && !w_is_mode) begin
                r_ff <= ~r_ff;
            end
            // A flag set in the same cycle as a status read survives to the next read
            r_tc_flags <= ((w_rd && w_is_mode) ? '0 : r_tc_flags) | w_tc_set;
            if (w_rd) begin
                if (w_is_mode) r_cpu_in <= {4'b0000, r_tc_flags};
                else           r_cpu_in <= r_ff ? w_rd_reg[AW-1:DW] : w_rd_reg[DW-1:0];
            end
        end
    end

    // Transfer FSM: bus request, address, read, device strobe
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_ch       <= 2'd0;
            r_hold     <= 1'b0;
            r_address  <= '0;
            r_dev_data <= '0;
            r_dev_we   <= 1'b0;
            r_dack     <= '0;
            r_tc       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|w_req) begin
                        r_hold  <= 1'b1;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (hlda) begin
                        if (|w_req) begin
                            r_ch    <= prio_sel(w_req);
                            r_state <= S_ADDR;
                        end else begin
                            r_hold  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_ADDR: begin
                    if (!hlda) begin
                        r_state <= S_REQ;
                    end else begin
                        r_address <= w_addr[r_ch];
                        r_state   <= S_READ;
                    end
                end
                S_READ: begin
                    // Losing the bus here abandons the byte before any register update
                    if (!hlda) begin
                        r_state <= S_REQ;
                    end else begin
                        r_dev_data <= in;
                        r_dev_we   <= (w_count[r_ch][AW-1:CW] == OP_READ);
                        r_dack     <= w_ch_oh;
                        r_tc       <= (w_count[r_ch][CW-1:0] == '0);
                        r_state    <= S_XFER;
                    end
                end
                S_XFER: begin
                    r_dev_we <= 1'b0;
                    r_dack   <= '0;
                    r_tc     <= 1'b0;
                    // Re-arbitrate with enables as they will stand after this cycle
                    if ((|w_req_nxt) && hlda) begin
                        r_ch    <= prio_sel(w_req_nxt);
                        r_state <= S_ADDR;
                    end else begin
                        r_hold  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_hold  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cpu_in   = r_cpu_in;
    assign hold     = r_hold;
    assign address  = r_address;
    assign dev_data = r_dev_data;
    assign dev_we   = r_dev_we;
    assign dack     = r_dack;
    assign tc       = r_tc;

endmodule

// File: tb/tb_vt57_dma.sv
// tb_vt57_dma: self-checking bench for vt57_dma (register table plus directed DMA sequences).
module tb_vt57_dma;

    localparam logic [15:0] BASE = 16'hE000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] cpu_address = '0;
    logic [7:0]  cpu_out = '0;
    logic        cpu_we = 1'b0;
    logic        cpu_rd = 1'b0;
    logic [7:0]  cpu_in;
    logic [3:0]  drq = '0;
    logic        hold;
    logic        hlda = 1'b0;
    logic [15:0] address;
    logic [7:0]  mem_in;
    logic [7:0]  dev_data;
    logic        dev_we;
    logic [3:0]  dack;
    logic        tc;

    int checks   = 0;
    int failures = 0;

    vt57_dma #(.BASE(BASE)) dut (
        .clock      (clock),
        .reset      (reset),
        .cpu_address(cpu_address),
        .cpu_out    (cpu_out),
        .cpu_we     (cpu_we),
        .cpu_rd     (cpu_rd),
        .cpu_in     (cpu_in),
        .drq        (drq),
        .hold       (hold),
        .hlda       (hlda),
        .address    (address),
        .in         (mem_in),
        .dev_data   (dev_data),
        .dev_we     (dev_we),
        .dack       (dack),
        .tc         (tc)
    );

    always #5 clock = ~clock;

    // Memory model: data is a fixed function of the address
    function automatic logic [7:0] mem_f(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction
    assign mem_in = mem_f(address);

    typedef struct {
        bit         we;
        bit         rd;
        logic [3:0] off;
        logic [7:0] d;
        logic [7:0] exp;
    } vec_t;

    localparam int NV = 27;
    vec_t tbl [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [3:0] off, input logic [7:0] d);
        @(negedge clock);
        cpu_address = BASE + 16'(off);
        cpu_out     = d;
        cpu_we      = 1'b1;
        @(negedge clock);
        cpu_we      = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [3:0] off, input logic [7:0] exp);
        @(negedge clock);
        cpu_address = BASE + 16'(off);
        cpu_rd      = 1'b1;
        @(negedge clock);
        cpu_rd      = 1'b0;
        check(name, 32'(cpu_in), 32'(exp));
    endtask

    task automatic prog(input int ch, input logic [15:0] a, input logic [15:0] c);
        wr(4'(2 * ch), a[7:0]);
        wr(4'(2 * ch), a[15:8]);
        wr(4'(2 * ch + 1), c[7:0]);
        wr(4'(2 * ch + 1), c[15:8]);
    endtask

    // Returns at the negedge where dev_we/dack is seen; n = negedges waited
    task automatic wait_pulse(input string name, output int n);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (dack == 4'b0000 && n < 200);
        if (dack == 4'b0000) check({name, "_timeout"}, 32'(dack != 4'b0000), 32'd1);
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        drq    = '0;
        hlda   = 1'b0;
        cpu_we = 1'b0;
        cpu_rd = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset  = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cnt;

        // Register access vectors: {we, rd, offset, wdata, expected cpu_in}
        tbl[0]  = '{1'b1, 1'b0, 4'd0, 8'h34, 8'h00};
        tbl[1]  = '{1'b1, 1'b0, 4'd0, 8'h12, 8'h00};
        tbl[2]  = '{1'b0, 1'b1, 4'd0, 8'h00, 8'h34};
        tbl[3]  = '{1'b0, 1'b1, 4'd0, 8'h00, 8'h12};
        tbl[4]  = '{1'b1, 1'b0, 4'd3, 8'hFF, 8'h00};
        tbl[5]  = '{1'b1, 1'b0, 4'd3, 8'h80, 8'h00};
        tbl[6]  = '{1'b0, 1'b1, 4'd3, 8'h00, 8'hFF};
        tbl[7]  = '{1'b0, 1'b1, 4'd3, 8'h00, 8'h80};
        tbl[8]  = '{1'b1, 1'b0, 4'd0, 8'hAA, 8'h00};
        tbl[9]  = '{1'b1, 1'b0, 4'd8, 8'h00, 8'h00};
        tbl[10] = '{1'b1, 1'b0, 4'd0, 8'h55, 8'h00};
        tbl[11] = '{1'b1, 1'b0, 4'd0, 8'h12, 8'h00};
        tbl[12] = '{1'b0, 1'b1, 4'd0, 8'h00, 8'h55};
        tbl[13] = '{1'b0, 1'b1, 4'd0, 8'h00, 8'h12};
        tbl[14] = '{1'b1, 1'b1, 4'd0, 8'h77, 8'h00};
        tbl[15] = '{1'b1, 1'b0, 4'd0, 8'h12, 8'h00};
        tbl[16] = '{1'b0, 1'b1, 4'd0, 8'h00, 8'h77};
        tbl[17] = '{1'b0, 1'b1, 4'd0, 8'h00, 8'h12};
        tbl[18] = '{1'b1, 1'b0, 4'd8, 8'h80, 8'h00};
        tbl[19] = '{1'b1, 1'b0, 4'd4, 8'h11, 8'h00};
        tbl[20] = '{1'b1, 1'b0, 4'd4, 8'h22, 8'h00};
        tbl[21] = '{1'b0, 1'b1, 4'd6, 8'h00, 8'h11};
        tbl[22] = '{1'b0, 1'b1, 4'd6, 8'h00, 8'h22};
        tbl[23] = '{1'b0, 1'b1, 4'd8, 8'h00, 8'h00};
        tbl[24] = '{1'b1, 1'b0, 4'd9, 8'h99, 8'h00};
        tbl[25] = '{1'b0, 1'b1, 4'd0, 8'h00, 8'h77};
        tbl[26] = '{1'b1, 1'b0, 4'd8, 8'h00, 8'h00};

        // Reset state
        do_reset();
        check("rst_hold", 32'(hold), 32'd0);
        check("rst_dack", 32'(dack), 32'd0);
        check("rst_dev_we", 32'(dev_we), 32'd0);
        check("rst_tc", 32'(tc), 32'd0);
        check("rst_address", 32'(address), 32'd0);
        check("rst_dev_data", 32'(dev_data), 32'd0);
        check("rst_cpu_in", 32'(cpu_in), 32'd0);

        // Register table
        for (int i = 0; i < NV; i++) begin
            @(negedge clock);
            cpu_address = BASE + 16'(tbl[i].off);
            cpu_out     = tbl[i].d;
            cpu_we      = tbl[i].we;
            cpu_rd      = tbl[i].rd;
            @(negedge clock);
            cpu_we = 1'b0;
            cpu_rd = 1'b0;
            if (tbl[i].rd && !tbl[i].we)
                check($sformatf("vec%0d", i), 32'(cpu_in), 32'(tbl[i].exp));
        end

        // A: 80-byte read on ch2
        do_reset();
        prog(2, 16'hE6A0, 16'h804F);
        wr(4'd8, 8'h04);
        hlda = 1'b1;
        drq  = 4'b0100;
        for (int k = 0; k < 80; k++) begin
            wait_pulse("A", n);
            if (dack == 4'b0000) break;
            check(k == 0 ? "A_latency" : "A_gap", 32'(n), k == 0 ? 32'd4 : 32'd3);
            check($sformatf("A_addr%0d", k), 32'(address), 32'(16'hE6A0 + 16'(k)));
            check("A_data", 32'(dev_data), 32'(mem_f(16'hE6A0 + 16'(k))));
            check("A_we", 32'(dev_we), 32'd1);
            check("A_dack", 32'(dack), 32'h4);
            check($sformatf("A_tc%0d", k), 32'(tc), 32'(k == 79));
            if (k == 79) drq = 4'b0000;
        end
        drq = 4'b0000;
        @(negedge clock);
        check("A_hold_off", 32'(hold), 32'd0);
        rd_chk("A_status", 4'd8, 8'h04);
        rd_chk("A_status_clr", 4'd8, 8'h00);
        rd_chk("A_addr_lo", 4'd4, 8'hF0);
        rd_chk("A_addr_hi", 4'd4, 8'hE6);
        rd_chk("A_cnt_lo", 4'd5, 8'hFF);
        rd_chk("A_cnt_hi", 4'd5, 8'hBF);

        // B: autoload reloads ch2 from ch3 and keeps it enabled
        do_reset();
        wr(4'd8, 8'hC4);
        prog(2, 16'hE6A0, 16'h8003);
        hlda = 1'b1;
        drq  = 4'b0100;
        for (int k = 0; k < 6; k++) begin
            wait_pulse("B", n);
            if (dack == 4'b0000) break;
            check($sformatf("B_addr%0d", k), 32'(address), 32'(16'hE6A0 + 16'(k % 4)));
            check($sformatf("B_tc%0d", k), 32'(tc), 32'(k == 3));
            if (k == 5) drq = 4'b0000;
        end
        drq = 4'b0000;
        @(negedge clock);
        rd_chk("B_status", 4'd8, 8'h04);
        rd_chk("B_addr_lo", 4'd4, 8'hA2);
        rd_chk("B_addr_hi", 4'd4, 8'hE6);
        rd_chk("B_cnt_lo", 4'd5, 8'h01);
        rd_chk("B_cnt_hi", 4'd5, 8'h80);

        // C: TC-stop without autoload disables the channel
        do_reset();
        prog(2, 16'hE6A0, 16'h8003);
        wr(4'd8, 8'h44);
        hlda = 1'b1;
        drq  = 4'b0100;
        for (int k = 0; k < 4; k++) begin
            wait_pulse("C", n);
            if (dack == 4'b0000) break;
            check($sformatf("C_addr%0d", k), 32'(address), 32'(16'hE6A0 + 16'(k)));
            check($sformatf("C_tc%0d", k), 32'(tc), 32'(k == 3));
        end
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (dack != 4'b0000) cnt++;
        end
        check("C_no_more_dack", 32'(cnt), 32'd0);
        check("C_hold_off", 32'(hold), 32'd0);
        drq = 4'b0000;
        rd_chk("C_status", 4'd8, 8'h04);

        // D: fixed priority, then re-arbitration inside a burst
        do_reset();
        prog(0, 16'h0100, 16'h800F);
        prog(2, 16'h0200, 16'h800F);
        wr(4'd8, 8'h05);
        hlda = 1'b1;
        drq  = 4'b0101;
        wait_pulse("D1", n);
        check("D1_dack", 32'(dack), 32'h1);
        check("D1_addr", 32'(address), 32'h0100);
        wait_pulse("D2", n);
        check("D2_dack", 32'(dack), 32'h1);
        check("D2_addr", 32'(address), 32'h0101);
        drq = 4'b0100;
        wait_pulse("D3", n);
        check("D3_gap", 32'(n), 32'd3);
        check("D3_dack", 32'(dack), 32'h4);
        check("D3_addr", 32'(address), 32'h0200);
        drq = 4'b0000;

        // E: delayed grant, then grant lost during READ
        do_reset();
        prog(1, 16'h3000, 16'h8002);
        wr(4'd8, 8'h02);
        drq = 4'b0010;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            check("E_hold_wait", 32'(hold), 32'd1);
            check("E_addr_wait", 32'(address), 32'd0);
            check("E_we_wait", 32'(dev_we), 32'd0);
        end
        hlda = 1'b1;
        wait_pulse("E1", n);
        check("E1_latency", 32'(n), 32'd3);
        check("E1_addr", 32'(address), 32'h3000);
        check("E1_dack", 32'(dack), 32'h2);
        @(negedge clock);
        @(negedge clock);
        check("E_read_addr", 32'(address), 32'h3001);
        hlda = 1'b0;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (dev_we || dack != 4'b0000) cnt++;
            check("E_hold_abort", 32'(hold), 32'd1);
        end
        check("E_no_xfer", 32'(cnt), 32'd0);
        rd_chk("E_cnt_lo", 4'd3, 8'h01);
        rd_chk("E_cnt_hi", 4'd3, 8'h80);
        rd_chk("E_addr_lo", 4'd2, 8'h01);
        rd_chk("E_addr_hi", 4'd2, 8'h30);
        hlda = 1'b1;
        wait_pulse("E2", n);
        check("E2_addr", 32'(address), 32'h3001);
        check("E2_tc", 32'(tc), 32'd0);
        wait_pulse("E3", n);
        check("E3_addr", 32'(address), 32'h3002);
        check("E3_tc", 32'(tc), 32'd1);
        drq = 4'b0000;

        // F: address wrap FFFF -> 0000
        do_reset();
        prog(1, 16'hFFFF, 16'h8001);
        wr(4'd8, 8'h02);
        hlda = 1'b1;
        drq  = 4'b0010;
        wait_pulse("F1", n);
        check("F1_addr", 32'(address), 32'hFFFF);
        check("F1_tc", 32'(tc), 32'd0);
        wait_pulse("F2", n);
        check("F2_addr", 32'(address), 32'h0000);
        check("F2_data", 32'(dev_data), 32'(mem_f(16'h0000)));
        check("F2_tc", 32'(tc), 32'd1);
        drq = 4'b0000;

        // G: CPU write in the XFER cycle overrides the increment
        do_reset();
        prog(1, 16'h1000, 16'h8000);
        wr(4'd8, 8'h02);
        hlda = 1'b1;
        drq  = 4'b0010;
        wait_pulse("G", n);
        check("G_tc", 32'(tc), 32'd1);
        cpu_address = BASE + 16'd2;
        cpu_out     = 8'h34;
        cpu_we      = 1'b1;
        drq         = 4'b0000;
        @(negedge clock);
        cpu_we = 1'b0;
        wr(4'd8, 8'h00);
        rd_chk("G_addr_lo", 4'd2, 8'h34);
        rd_chk("G_addr_hi", 4'd2, 8'h10);
        rd_chk("G_cnt_lo", 4'd3, 8'hFF);
        rd_chk("G_cnt_hi", 4'd3, 8'hBF);

        // H: reset asserted during XFER
        do_reset();
        prog(0, 16'h4000, 16'h8005);
        wr(4'd8, 8'h01);
        hlda = 1'b1;
        drq  = 4'b0001;
        wait_pulse("H", n);
        check("H_we_before", 32'(dev_we), 32'd1);
        reset = 1'b1;
        #1;
        check("H_hold", 32'(hold), 32'd0);
        check("H_dack", 32'(dack), 32'd0);
        check("H_dev_we", 32'(dev_we), 32'd0);
        check("H_tc", 32'(tc), 32'd0);
        check("H_address", 32'(address), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("H_no_hold", 32'(hold), 32'd0);
        end
        drq = 4'b0000;
        rd_chk("H_addr_lo", 4'd0, 8'h00);
        rd_chk("H_addr_hi", 4'd0, 8'h00);
        rd_chk("H_cnt_lo", 4'd1, 8'h00);
        rd_chk("H_status", 4'd8, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
